prfc_lookup_dispatcher: RTL and testbench
=========================================

// Module: prfc_lookup_dispatcher
// PURPOSE
//  Shares a pool of NUM_CLS prfc classifier instances between one packet-header stream.
//  Accepts 6-dim headers on a valid/ready input and dispatches them round-robin to idle classifiers.
//  Starts each lookup with a one-cycle start pulse and captures each classifier's result on lookup_done.
//  Returns results on a valid/ready output in strict arrival order. Sits between packet parser and action stage.
// PARAMETERS
//  NUM_CLS     4   number of classifier slots (>=1, any value; pointers wrap explicitly at NUM_CLS-1)
//  DATA_WIDTH  32  classifier lookup_result width
//  CNT_WIDTH   32  width of packet statistics counters
// PORTS
//  clk          in   1               single clock, all logic rising-edge
//  rst          in   1               synchronous, active-high reset
//  in_valid     in   1               header valid
//  in_ready     out  1               dispatcher can accept header this cycle
//  in_dims      in   96              {dim5,dim4,dim3,dim2,dim1,dim0}, 16b each
//  cls_start    out  NUM_CLS         per-slot start_lookup pulse
//  cls_dims     out  NUM_CLS*96      per-slot packet_dims, held stable while slot BUSY
//  cls_done     in   NUM_CLS         per-slot lookup_done
//  cls_result   in   NUM_CLS*DATA_WIDTH  per-slot lookup_result, sampled when cls_done=1
//  out_valid    out  1               ordered result available
//  out_ready    in   1               downstream accepts result
//  out_result   out  DATA_WIDTH      classification result (matched rule/priority)
//  in_flight    out  $clog2(NUM_CLS+1)   slots not IDLE
//  pkt_in_cnt   out  CNT_WIDTH       headers accepted (wraps at 2^CNT_WIDTH)
//  pkt_out_cnt  out  CNT_WIDTH       results delivered (wraps)
//  err_spurious out  1               sticky: cls_done seen on a slot not BUSY
// BEHAVIOUR
//  Reset: all slots IDLE, wr_ptr=rd_ptr=0, cls_start=0, cls_dims=0, out_valid=0, out_result=0,
//   counters=0, err_spurious=0, in_flight=0. Classifiers share this reset (driven rst_n=~rst).
//  Reset mid-operation abandons all lookups; no partial result is delivered.
//  Per-slot FSM: IDLE -(accept, wr_ptr==slot)-> BUSY -(cls_done)-> DONE -(out handshake, rd_ptr==slot)-> IDLE.
//  in_ready = (slot[wr_ptr]==IDLE), combinational from registered state only (no ready->valid path).
//  Accept (in_valid&in_ready) at cycle T: latch in_dims into cls_dims[wr_ptr], slot->BUSY,
//   wr_ptr++ (wrap NUM_CLS-1 -> 0), pkt_in_cnt++. cls_start[slot]=1 for exactly cycle T+1.
//  cls_done[s]=1 while slot s BUSY (including the start-pulse cycle): capture cls_result[s], slot->DONE next cycle.
//  cls_done[s] while s IDLE or DONE: ignored, result not captured, err_spurious<=1 (cleared only by rst).
//  out_valid = (slot[rd_ptr]==DONE); out_result = captured result of slot rd_ptr; stable until handshake.
//  Output handshake (out_valid&out_ready): slot->IDLE, rd_ptr++ (wrap), pkt_out_cnt++.
//  A slot freed at cycle T shows in_ready only from T+1 (one-cycle reuse bubble); no same-cycle free+accept.
//  Min latency: accept T -> start T+1 -> done D -> out_valid D+1.
//  Results are never reordered: a later slot that is DONE waits until all earlier slots drain.
//  Simultaneous accept, multiple cls_done and output handshake in one cycle are all honoured independently.
//  All slots BUSY/DONE: in_ready=0; backpressure holds indefinitely, no data lost.
//  in_flight updates on the cycle after the state change; range 0..NUM_CLS.
// TESTING
//  1 Single header 0x0001..0x0006, slot 0 done 5 cycles after start with 0x2A -> cls_start[0] one cycle at T+1, out_valid D+1, out_result=0x2A, cnts=1/1.
//  2 Four headers back-to-back, dones in order 3,1,0,2 -> outputs in order slot0,1,2,3 results; out_valid only after slot0 done.
//  3 Fill all 4 slots, hold out_ready=0 -> in_ready=0, 5th header held; release out_ready -> 5th accepted into slot0, one cycle after slot0 frees.
//  4 cls_done[2] pulsed while slot 2 IDLE -> err_spurious=1 sticky, no out_valid, counters unchanged.
//  5 rst asserted with 3 slots BUSY -> next cycle all outputs at reset values; later cls_done pulses produce no output.
//  6 NUM_CLS=3, 7 headers with random done delays and random out_ready -> in-order results, wr/rd pointers wrap 2->0, pkt_in_cnt=pkt_out_cnt=7.

Source files
------------

// File: rtl/prfc_lookup_dispatcher.sv
// Round-robin dispatcher sharing NUM_CLS prfc classifiers across one header stream;
// results leave in strict arrival order through a valid/ready output.
//
// state     | meaning
// ST_IDLE   | slot free, may accept the header at wr_ptr
// ST_BUSY   | lookup running, cls_dims held, waiting for cls_done
// ST_DONE   | result captured, waiting for its turn at rd_ptr
module prfc_lookup_dispatcher #(
  parameter int NUM_CLS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [95:0]                     in_dims,
  output logic [NUM_CLS-1:0]              cls_start,
  output logic [NUM_CLS*96-1:0]           cls_dims,
  input  logic [NUM_CLS-1:0]              cls_done,
  input  logic [NUM_CLS*DATA_WIDTH-1:0]   cls_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_result,
  output logic [$clog2(NUM_CLS+1)-1:0]    in_flight,
  output logic [CNT_WIDTH-1:0]            pkt_in_cnt,
  output logic [CNT_WIDTH-1:0]            pkt_out_cnt,
  output logic                            err_spurious
);

  localparam int PTR_W = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
  localparam int FL_W  = $clog2(NUM_CLS + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CLS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            slot_st  [NUM_CLS];
  logic [DATA_WIDTH-1:0] slot_res [NUM_CLS];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  accept;
  logic                  deliver;
  logic [FL_W-1:0]       busy_cnt;

  // Ready and valid look only at registered slot state, so no ready->valid path exists.
  assign in_ready   = (slot_st[wr_ptr] == ST_IDLE);
  assign out_valid  = (slot_st[rd_ptr] == ST_DONE);
  assign out_result = slot_res[rd_ptr];
  assign accept     = in_valid & in_ready;
  assign deliver    = out_valid & out_ready;
  assign in_flight  = busy_cnt;

  always_comb begin
    busy_cnt = '0;
    for (int s = 0; s < NUM_CLS; s++) begin
      if (slot_st[s] != ST_IDLE) busy_cnt = busy_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_CLS; s++) begin
        slot_st[s]  <= ST_IDLE;
        slot_res[s] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cls_start    <= '0;
      cls_dims     <= '0;
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      err_spurious <= 1'b0;
    end else begin
      cls_start <= '0;
      if (accept) begin
        wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        pkt_in_cnt <= pkt_in_cnt + 1'b1;
      end
      if (deliver) begin
        rd_ptr      <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        pkt_out_cnt <= pkt_out_cnt + 1'b1;
      end
      for (int s = 0; s < NUM_CLS; s++) begin
        case (slot_st[s])
          ST_IDLE: begin
            if (accept && (wr_ptr == PTR_W'(s))) begin
              slot_st[s]           <= ST_BUSY;
              cls_start[s]         <= 1'b1;
              cls_dims[s*96 +: 96] <= in_dims;
            end
          end
          ST_BUSY: begin
            if (cls_done[s]) begin
              slot_st[s]  <= ST_DONE;
              slot_res[s] <= cls_result[s*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          ST_DONE: begin
            if (deliver && (rd_ptr == PTR_W'(s))) slot_st[s] <= ST_IDLE;
          end
          default: slot_st[s] <= ST_IDLE;
        endcase
        // A done from a slot with no lookup running is dropped but remembered.
        if (cls_done[s] && (slot_st[s] != ST_BUSY)) err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prfc_lookup_dispatcher.sv
// Directed bench for prfc_lookup_dispatcher: a 4-slot instance for table vectors and
// corner sequences, and a 3-slot instance for an ordered random-latency run.
module tb_prfc_lookup_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  // 4-slot instance
  logic         in_valid, in_ready, out_valid, out_ready, err_spurious;
  logic [95:0]  in_dims;
  logic [3:0]   cls_start, cls_done;
  logic [383:0] cls_dims;
  logic [127:0] cls_result;
  logic [31:0]  out_result, pkt_in_cnt, pkt_out_cnt;
  logic [2:0]   in_flight;

  // 3-slot instance
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_spurious_b;
  logic [95:0]  in_dims_b;
  logic [2:0]   cls_start_b, cls_done_b;
  logic [287:0] cls_dims_b;
  logic [95:0]  cls_result_b;
  logic [31:0]  out_result_b, pkt_in_cnt_b, pkt_out_cnt_b;
  logic [1:0]   in_flight_b;

  prfc_lookup_dispatcher #(.NUM_CLS(4), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dims(in_dims),
    .cls_start(cls_start), .cls_dims(cls_dims), .cls_done(cls_done), .cls_result(cls_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .in_flight(in_flight), .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt),
    .err_spurious(err_spurious));

  prfc_lookup_dispatcher #(.NUM_CLS(3), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_dims(in_dims_b),
    .cls_start(cls_start_b), .cls_dims(cls_dims_b), .cls_done(cls_done_b), .cls_result(cls_result_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_result(out_result_b),
    .in_flight(in_flight_b), .pkt_in_cnt(pkt_in_cnt_b), .pkt_out_cnt(pkt_out_cnt_b),
    .err_spurious(err_spurious_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cls_done = '0; cls_result = '0; in_dims = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done(input int s, input logic [31:0] r);
    cls_done = 4'(1) << s;
    cls_result[s*32 +: 32] = r;
    tick();
    cls_done = '0;
    cls_result = '1;
  endtask

  function automatic logic [95:0] dims_b(input int k);
    return {16'(k), 16'h00D4, 16'h00D3, 16'h00D2, 16'h00D1, 16'(k + 16'h100)};
  endfunction

  typedef struct {
    logic [95:0] dims;
    int          delay;
    logic [31:0] res;
    int          slot;
    logic [3:0]  exp_start;
  } vec_t;
  vec_t vt[4];

  int          cnt_b [3];
  logic [31:0] res_b [3];
  logic [31:0] exp_q [$];
  int sent, rcvd, nstart, cyc;
  logic acc, hs;
  logic [31:0] want;

  initial begin
    vt[0] = '{{16'h0006,16'h0005,16'h0004,16'h0003,16'h0002,16'h0001}, 5, 32'h0000_002A, 0, 4'b0001};
    vt[1] = '{96'h1111_2222_3333_4444_5555_6666, 1, 32'hDEAD_BEEF, 1, 4'b0010};
    vt[2] = '{96'hFFFF_0000_FFFF_0000_FFFF_0000, 0, 32'h0000_0001, 2, 4'b0100};
    vt[3] = '{96'h0123_4567_89AB_CDEF_0F1E_2D3C, 3, 32'h8000_0001, 3, 4'b1000};

    in_valid_b = 1'b0; in_dims_b = '0; cls_done_b = '0; cls_result_b = '0; out_ready_b = 1'b0;
    do_reset();

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_in_flight", in_flight, 3'd0);

    // Table vectors: one header at a time, slots rotate 0..3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dims = vt[i].dims;
      chk("t_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("t_cls_start", cls_start, vt[i].exp_start);
      chk("t_cls_dims", cls_dims[vt[i].slot*96 +: 96], vt[i].dims);
      chk("t_in_flight", in_flight, 3'd1);
      if (vt[i].delay > 0) begin
        tick();
        chk("t_start_one_cycle", cls_start, 4'b0000);
        for (int d = 1; d < vt[i].delay; d++) tick();
      end
      chk("t_no_early_valid", out_valid, 1'b0);
      pulse_done(vt[i].slot, vt[i].res);
      chk("t_out_valid", out_valid, 1'b1);
      chk("t_out_result", out_result, vt[i].res);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t_valid_clear", out_valid, 1'b0);
      chk("t_pkt_in", pkt_in_cnt, 32'(i + 1));
      chk("t_pkt_out", pkt_out_cnt, 32'(i + 1));
      chk("t_idle", in_flight, 3'd0);
    end

    // Back-to-back fill, dones out of order 3,1,0,2
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_dims = {6{16'(k + 1)}};
      chk("b2b_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_full_ready", in_ready, 1'b0);
    chk("b2b_in_flight", in_flight, 3'd4);
    pulse_done(3, 32'h103);
    chk("b2b_wait_slot0_a", out_valid, 1'b0);
    pulse_done(1, 32'h101);
    chk("b2b_wait_slot0_b", out_valid, 1'b0);
    pulse_done(0, 32'h100);
    chk("b2b_slot0_valid", out_valid, 1'b1);
    chk("b2b_slot0_res", out_result, 32'h100);
    pulse_done(2, 32'h102);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_order_valid", out_valid, 1'b1);
      chk("b2b_order_res", out_result, 32'(32'h100 + k));
      tick();
    end
    out_ready = 1'b0;
    chk("b2b_drained", out_valid, 1'b0);
    chk("b2b_cnt_out", pkt_out_cnt, 32'd4);

    // Backpressure: all slots DONE, 5th header held until slot0 frees
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_dims = {6{16'(k + 16'h30)}};
      tick();
    end
    cls_done = 4'hF;
    cls_result = {32'h303, 32'h302, 32'h301, 32'h300};
    in_dims = 96'h5555_5555_5555_5555_5555_5555;
    tick();
    cls_done = '0; cls_result = '1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready_low", in_ready, 1'b0);
      tick();
    end
    chk("bp_pkt_in_held", pkt_in_cnt, 32'd4);
    out_ready = 1'b1;
    chk("bp_no_same_cycle_reuse", in_ready, 1'b0);
    chk("bp_first_res", out_result, 32'h300);
    tick();
    out_ready = 1'b0;
    chk("bp_ready_after_free", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_5th_start", cls_start, 4'b0001);
    chk("bp_5th_dims", cls_dims[95:0], 96'h5555_5555_5555_5555_5555_5555);
    chk("bp_pkt_in", pkt_in_cnt, 32'd5);
    chk("bp_next_res", out_result, 32'h301);

    // Spurious done on an idle slot
    do_reset();
    pulse_done(2, 32'h77);
    chk("sp_err_set", err_spurious, 1'b1);
    chk("sp_no_valid", out_valid, 1'b0);
    chk("sp_cnt_in", pkt_in_cnt, 32'd0);
    tick(); tick();
    chk("sp_err_sticky", err_spurious, 1'b1);
    chk("sp_cnt_out", pkt_out_cnt, 32'd0);

    // Reset with three lookups in flight
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_dims = {6{16'(k + 16'h50)}};
      tick();
    end
    in_valid = 1'b0;
    chk("mr_in_flight_pre", in_flight, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready", in_ready, 1'b1);
    chk("mr_cls_start", cls_start, 4'b0000);
    chk("mr_cls_dims", cls_dims, 384'h0);
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_out_result", out_result, 32'h0);
    chk("mr_cnt_in", pkt_in_cnt, 32'd0);
    chk("mr_in_flight", in_flight, 3'd0);
    chk("mr_err", err_spurious, 1'b0);
    cls_done = 4'b0111; cls_result = {32'h0, 32'h92, 32'h91, 32'h90};
    tick();
    cls_done = '0;
    tick();
    chk("mr_late_done_no_out", out_valid, 1'b0);
    chk("mr_late_done_err", err_spurious, 1'b1);
    chk("mr_late_cnt_out", pkt_out_cnt, 32'd0);

    // 3-slot run, random done latency and random out_ready
    do_reset();
    for (int s = 0; s < 3; s++) begin cnt_b[s] = -1; res_b[s] = '0; end
    sent = 0; rcvd = 0; nstart = 0; cyc = 0;
    while (rcvd < 7 && cyc < 1000) begin
      cls_done_b = '0;
      for (int s = 0; s < 3; s++) begin
        if (cls_start_b[s]) begin
          cnt_b[s] = int'($urandom_range(0, 4));
          res_b[s] = {cls_dims_b[s*96+80 +: 16], cls_dims_b[s*96 +: 16]};
        end
        if (cnt_b[s] == 0) begin
          cls_done_b[s] = 1'b1;
          cls_result_b[s*32 +: 32] = res_b[s];
          cnt_b[s] = -1;
        end else if (cnt_b[s] > 0) begin
          cnt_b[s] = cnt_b[s] - 1;
          cls_result_b[s*32 +: 32] = 32'hBAD0_0000;
        end
      end
      if (cls_start_b != 3'b000) begin
        chk("r_start_slot", cls_start_b, 3'(1) << (nstart % 3));
        nstart++;
      end
      in_valid_b  = (sent < 7);
      in_dims_b   = dims_b(sent);
      out_ready_b = 1'($urandom_range(0, 1));
      acc = in_valid_b & in_ready_b;
      hs  = out_valid_b & out_ready_b;
      if (hs) begin
        if (exp_q.size() == 0) chk("r_unexpected_out", out_valid_b, 1'b0);
        else begin
          want = exp_q.pop_front();
          chk("r_out_result", out_result_b, want);
        end
        rcvd++;
      end
      if (acc) begin
        exp_q.push_back({in_dims_b[95:80], in_dims_b[15:0]});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid_b = 1'b0; out_ready_b = 1'b0; cls_done_b = '0;
    chk("r_all_received", 32'(rcvd), 32'd7);
    chk("r_pkt_in", pkt_in_cnt_b, 32'd7);
    chk("r_pkt_out", pkt_out_cnt_b, 32'd7);
    chk("r_in_flight", in_flight_b, 2'd0);
    chk("r_err", err_spurious_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
